// File: rtl/multicycle_control.sv
// Main sequencer for the multicycle datapath: FETCH..WRITEBACK with memory wait/timeout handling.
// Outputs are combinational from state/Op/MemReady; memory states stall on MemReady, capped by WAIT_LIMIT.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IllegalOp,
    output logic       MemTimeout,
    output logic [3:0] State
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          run;
    logic          is_wait;
    logic          timeout;

    // Branch qualification lives in the datapath; Zero is accepted but not needed here.
    logic unused_zero;
    assign unused_zero = Zero;

    // run stays low until the first edge that samples RSTn high, keeping every output quiet.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            run      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            run      <= 1'b1;
        end
    end

    assign State = state;

    always_comb begin
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'd0;
        ALUOp        = 2'd0;
        PCSrc        = 2'd0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IllegalOp    = 1'b0;
        MemTimeout   = 1'b0;
        state_nxt    = S_FETCH;
        wait_cnt_nxt = '0;
        is_wait      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
        timeout      = run && is_wait && !MemReady && (wait_cnt == LIMIT);

        if (run) begin
            if (is_wait && !MemReady && !timeout)
                wait_cnt_nxt = wait_cnt + CW'(1);
            MemTimeout = timeout;

            case (state)
                S_FETCH: begin
                    MemRead   = !timeout;
                    ALUSrcB   = 2'd1;
                    IRWrite   = MemReady;
                    PCWrite   = MemReady;
                    state_nxt = MemReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ALUSrcB = 2'd3;
                    case (Op)
                        OP_LW, OP_SW: state_nxt = S_MEMADR;
                        OP_R:         state_nxt = S_EXEC;
                        OP_BEQ:       state_nxt = S_BRANCH;
                        OP_J:         state_nxt = S_JUMP;
                        OP_ADDI:      state_nxt = S_ADDIEX;
                        default: begin
                            IllegalOp = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    if (Op == OP_LW)
                        state_nxt = S_MEMRD;
                    else if (Op == OP_SW)
                        state_nxt = S_MEMWR;
                    else
                        state_nxt = S_FETCH;
                end
                S_MEMRD: begin
                    MemRead   = !timeout;
                    IorD      = 1'b1;
                    state_nxt = MemReady ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite  = !timeout;
                    IorD      = 1'b1;
                    state_nxt = (MemReady || timeout) ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    ALUSrcA   = 1'b1;
                    ALUOp     = 2'd2;
                    state_nxt = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'd1;
                    PCSrc       = 2'd1;
                    PCWriteCond = 1'b1;
                end
                S_JUMP: begin
                    PCSrc   = 2'd2;
                    PCWrite = 1'b1;
                end
                S_ADDIEX: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'd2;
                    state_nxt = S_ADDIWB;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each instruction expands into its expected per-cycle state/output trace, checked every cycle.
module tb_multicycle_control;

    localparam int WL = 3;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, PCWriteCond, IllegalOp, MemTimeout;
    logic [3:0] State;

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .CLK(CLK), .RSTn(RSTn), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .IllegalOp(IllegalOp), .MemTimeout(MemTimeout),
        .State(State)
    );

    always #5 CLK = ~CLK;

    logic [21:0] dut_vec;
    assign dut_vec = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                      ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond, IllegalOp, MemTimeout, State};

    int          vectors = 0;
    int          miscompares = 0;
    int          ncyc;
    bit          exp_vld = 1'b0;
    logic [21:0] exp_vec;
    string       tag = "";
    int          pin_st = -1;
    logic [21:0] pin_val;

    // Expected controls for a state, straight from the per-state output table.
    function automatic logic [21:0] ctl(input int st, input bit mr, input bit to, input bit ill);
        logic iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcw, pcwc, il, mt;
        logic [1:0] asb, aop, pcs;
        {iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcw, pcwc, il, mt} = '0;
        asb = 2'd0; aop = 2'd0; pcs = 2'd0;
        case (st)
            0:  begin mrd = !to; asb = 2'd1; irw = mr; pcw = mr; mt = to; end
            1:  begin asb = 2'd3; il = ill; end
            2:  begin asa = 1'b1; asb = 2'd2; end
            3:  begin mrd = !to; iord = 1'b1; mt = to; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mwr = !to; iord = 1'b1; mt = to; end
            6:  begin asa = 1'b1; aop = 2'd2; end
            7:  begin rw = 1'b1; rdst = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'd1; pcs = 2'd1; pcwc = 1'b1; end
            9:  begin pcs = 2'd2; pcw = 1'b1; end
            10: begin asa = 1'b1; asb = 2'd2; end
            11: begin rw = 1'b1; end
            default: ;
        endcase
        return {iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, pcw, pcwc, il, mt, 4'(st)};
    endfunction

    always @(negedge CLK) begin
        if (exp_vld) begin
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL %s: outputs=%h expected=%h (state %0d vs %0d)",
                         tag, dut_vec, exp_vec, State, exp_vec[3:0]);
            end
        end
    end

    task automatic check(input bit ok, input string name, input int got, input int want);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // One clock cycle: drive MemReady, publish the expectation, advance to just past the next edge.
    task automatic cyc(input int st, input bit mr, input bit to, input bit ill, input string t);
        MemReady = mr;
        exp_vec  = ctl(st, mr, to, ill);
        tag      = t;
        exp_vld  = 1'b1;
        @(negedge CLK);
        if (st == pin_st) begin
            vectors++;
            if (dut_vec !== pin_val) begin
                miscompares++;
                $display("FAIL %s literal: outputs=%h expected=%h", t, dut_vec, pin_val);
            end
            pin_st = -1;
        end
        @(posedge CLK);
        #1;
        ncyc++;
    endtask

    task automatic cyc_any(input int st, input string t);
        cyc(st, 1'($urandom_range(0, 1)), 1'b0, 1'b0, t);
    endtask

    task automatic cyc_zero(input string t);
        MemReady = 1'b1;
        exp_vec  = '0;
        tag      = t;
        exp_vld  = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    // The WL+1-th consecutive not-ready cycle is a timeout; memory states abort on it.
    task automatic mem_wait(input int st, input int waits, input string t, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < waits && !aborted; i++) begin
            cyc(st, 1'b0, (i % (WL + 1)) == WL, 1'b0, t);
            aborted = (i % (WL + 1)) == WL;
        end
        if (!aborted) cyc(st, 1'b1, 1'b0, 1'b0, t);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input int cpi, input string t);
        bit legal, ab;
        ncyc  = 0;
        legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        for (int i = 0; i < fw; i++)
            cyc(0, 1'b0, (i % (WL + 1)) == WL, 1'b0, {t, " fetch-wait"});
        cyc(0, 1'b1, 1'b0, 1'b0, {t, " fetch"});
        Op = op;
        cyc(1, 1'($urandom_range(0, 1)), 1'b0, !legal, {t, " decode"});
        case (op)
            OP_R:    begin cyc_any(6, {t, " exec"}); cyc_any(7, {t, " aluwb"}); end
            OP_LW:   begin
                cyc_any(2, {t, " memadr"});
                mem_wait(3, mw, {t, " memrd"}, ab);
                if (!ab) cyc_any(4, {t, " memwb"});
            end
            OP_SW:   begin cyc_any(2, {t, " memadr"}); mem_wait(5, mw, {t, " memwr"}, ab); end
            OP_BEQ:  cyc_any(8, {t, " branch"});
            OP_J:    cyc_any(9, {t, " jump"});
            OP_ADDI: begin cyc_any(10, {t, " addiex"}); cyc_any(11, {t, " addiwb"}); end
            default: ;
        endcase
        check(ncyc == cpi, {t, " cycles"}, ncyc, cpi);
    endtask

    task automatic release_reset();
        cyc_zero("reset held");
        cyc_zero("reset held");
        RSTn = 1'b1;
        cyc_zero("reset release cycle");
    endtask

    initial begin
        RSTn = 1'b0; MemReady = 1'b1; Op = OP_R; Zero = 1'b0;
        #2;
        check(dut_vec == 22'd0, "async reset outputs", int'(dut_vec), 0);
        @(posedge CLK); #1;
        release_reset();

        // First active fetch pinned by hand: MemRead, IRWrite, PCWrite, ALUSrcB=1, state 0.
        pin_st = 0; pin_val = 22'b0101_0000_01_00_00_1000_0000;
        run_instr(OP_R,   0, 0, 4, "R");
        run_instr(OP_LW,  0, 2, 7, "LW 2 waits");
        pin_st = 8; pin_val = 22'b0000_0001_00_01_01_0100_1000;
        run_instr(OP_BEQ, 0, 0, 3, "BEQ");
        run_instr(OP_SW,  0, 0, 4, "SW");
        pin_st = 9; pin_val = 22'b0000_0000_00_00_10_1000_1001;
        run_instr(OP_J,   0, 0, 3, "J");
        pin_st = 1; pin_val = 22'b0000_0000_11_00_00_0010_0001;
        run_instr(6'b111111, 0, 0, 2, "illegal 3f");
        run_instr(6'b000011, 0, 0, 2, "illegal 03");
        run_instr(OP_ADDI, 0, 0, 4, "ADDI");
        run_instr(OP_LW,  0, 0, 5, "LW");
        run_instr(OP_R,   5, 0, 9, "R fetch timeout");
        run_instr(OP_R,   WL, 0, 4 + WL, "R fetch at limit");
        run_instr(OP_SW,  0, WL, 4 + WL, "SW write at limit");
        run_instr(OP_LW,  0, WL + 1, 7, "LW read timeout");
        run_instr(OP_SW,  0, WL + 1, 7, "SW write timeout");
        run_instr(OP_ADDI, 1, 0, 5, "ADDI after timeout");

        // Reset asserted mid-cycle while a store is waiting on memory.
        ncyc = 0;
        cyc(0, 1'b1, 1'b0, 1'b0, "rst fetch");
        Op = OP_SW;
        cyc_any(1, "rst decode");
        cyc_any(2, "rst memadr");
        MemReady = 1'b0;
        exp_vec  = ctl(5, 1'b0, 1'b0, 1'b0);
        tag      = "rst memwr";
        @(negedge CLK);
        #1;
        exp_vld = 1'b0;
        RSTn    = 1'b0;
        #1;
        check(MemWrite == 1'b0, "async reset MemWrite", int'(MemWrite), 0);
        check(State == 4'd0, "async reset State", int'(State), 0);
        check(dut_vec == 22'd0, "async reset all outputs", int'(dut_vec), 0);
        @(posedge CLK); #1;
        Op = OP_R;
        release_reset();
        run_instr(OP_R, 0, 0, 4, "R after reset");

        exp_vld = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multicycle datapath. It sequences every instruction through fetch, decode, execute, memory and writeback, and drives the instruction register enable (IRWrite) together with all other datapath enables and mux selects. It consumes the opcode field from the instruction register output and handshakes with a variable-latency unified memory through MemReady.

## Interface
- WAIT_LIMIT, 15: maximum wait cycles in a memory state before timeout (1..255).
- CLK  input  1  system clock, rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- Op  input  6  opcode, IR q[31:26].
- Zero  input  1  ALU zero flag (unused internally; branch qualification is done in the datapath via PCWriteCond).
- MemReady  input  1  memory completes the current read or write this cycle.
- IorD, MemRead, MemWrite, IRWrite  output  1 each  memory address select, read strobe, write strobe, IR enable.
- RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  register file and ALU A selects.
- ALUSrcB  output  2  ALU B select: 0 = reg B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- ALUOp  output  2  0 = add, 1 = sub, 2 = funct-decoded.
- PCSrc  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- PCWrite, PCWriteCond  output  1 each  unconditional / branch-qualified PC enable.
- IllegalOp, MemTimeout  output  1 each  one-cycle error pulses.
- State  output  4  current state encoding, for debug.

## Operation
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010. All others are illegal.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSrc=0. IRWrite=PCWrite=MemReady. Moves to DECODE on MemReady; otherwise holds.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0. Next state by Op: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX. Illegal opcode→FETCH with IllegalOp=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to MEMRD on LW, MEMWR on SW.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Then FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Then ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSrc=1, PCWriteCond=1. Then FETCH.
- JUMP: PCSrc=2, PCWrite=1. Then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
- Any output not listed for a state is 0.
- Wait counter (width ceil(log2(WAIT_LIMIT+1))):
  - Cleared on entry to FETCH, MEMRD and MEMWR, and whenever MemReady=1.
  - Increments each cycle spent in one of those states with MemReady=0.
  - When it reaches WAIT_LIMIT with MemReady still 0: MemTimeout=1 for one cycle, strobes drop, state goes to FETCH, counter clears. A timeout in FETCH therefore restarts the fetch of the same PC.
- Unused encodings 12–15 go to FETCH on the next edge, with all outputs 0.

## Timing
- RSTn low: state=FETCH and counter=0 immediately. All outputs are forced to 0, including MemRead, IRWrite and PCWrite, until RSTn is sampled high.
- Reset mid-instruction aborts it with no further writes.
- Outputs are combinational from state, Op and MemReady; the state register updates on the rising edge of CLK.
- IRWrite is high only in the FETCH cycle where MemReady=1. The IR captures on that same edge, and DECODE sees the new Op one cycle later.
- Cycles per instruction with zero-wait memory (MemReady=1 permanently): R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, illegal 2. Each wait cycle adds one.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset and R-type: reset release with MemReady=1 and Op=000000. Required state sequence 0,1,6,7,0; IRWrite high only in cycle 0; RegWrite=1 with RegDst=1 in state 7.
- LW with 2 wait states: MemReady low for 2 cycles in MEMRD. Required sequence 0,1,2,3,3,3,4,0; IorD=1 for all three MEMRD cycles; MemtoReg=1 and RegWrite=1 in state 4.
- BEQ, SW and J back-to-back with MemReady=1. Required: PCWriteCond=1 only in state 8, MemWrite=1 only in state 5, PCWrite=1 with PCSrc=2 in state 9, total 3+4+3 cycles.
- Illegal opcode 111111: sequence 0,1,0; IllegalOp pulses exactly once in DECODE; no RegWrite, MemWrite or PCWrite beyond the FETCH PCWrite.
- Timeout: WAIT_LIMIT=3, MemReady held 0 in FETCH. Required: MemTimeout pulses on the 4th FETCH cycle, the counter clears, IRWrite stays 0 throughout, and a later MemReady=1 loads the IR.
- Async reset during MEMWR: RSTn pulled low between clock edges. Required: MemWrite drops to 0 immediately and State=0 before the next edge.
